rv32m_muldiv: RTL

Iterative RV32M multiply/divide unit that sits between the register bank read ports and the register bank write port. It accepts operands rs1/rs2 plus destination index on a start pulse, computes any of the eight M-extension operations in a fixed 34-cycle sequence, then presents the result with a one-cycle write strobe for the register bank write port. It keeps x0 semantics by suppressing writes to register 0.

---
 rtl/rv32m_muldiv_if.sv | 18 +
 rtl/rv32m_muldiv.sv | 81 ++++++++
 2 files changed

// File: rtl/rv32m_muldiv_if.sv
// rv32m_muldiv_if: request/result bundle between the pipeline and the M-extension unit
interface rv32m_muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  dest;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  write_addr;
  logic        write_en;
  modport master (output start, funct3, op_a, op_b, dest, abort,
                  input busy, done, result, write_addr, write_en);
  modport slave  (input start, funct3, op_a, op_b, dest, abort,
                  output busy, done, result, write_addr, write_en);
endinterface

// File: rtl/rv32m_muldiv.sv
// rv32m_muldiv: iterative RV32M multiply/divide, fixed 34-cycle latency, x0 writes suppressed
module rv32m_muldiv (
  input logic clk,
  input logic rst_n,
  rv32m_muldiv_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q;
  logic [4:0]  dest_q, waddr_q;
  logic        neg_q, done_q, we_q;
  logic [31:0] mag_q, result_q, ma, mb, div_diff;
  logic [63:0] acc_q, acc_step, sel, fin;
  logic [32:0] mul_s;
  logic        busy, start_ok, fin_ok, is_mul, sa_en, sb_en, a_neg, b_neg, neg_new, div_ge;
  assign busy     = state_q != IDLE;
  assign start_ok = !busy && bus.start && !bus.abort;
  assign fin_ok   = state_q == FIN && !bus.abort;
  assign is_mul   = !bus.funct3[2];
  assign sa_en    = bus.funct3[2] ? !bus.funct3[0] : bus.funct3[0] ^ bus.funct3[1];
  assign sb_en    = bus.funct3[2] ? !bus.funct3[0] : bus.funct3[1:0] == 2'b01;
  assign a_neg    = sa_en && bus.op_a[31];
  assign b_neg    = sb_en && bus.op_b[31];
  assign ma       = a_neg ? -bus.op_a : bus.op_a;
  assign mb       = b_neg ? -bus.op_b : bus.op_b;
  // a zero divisor yields an all-ones quotient that must not be negated
  assign neg_new  = is_mul ? a_neg ^ b_neg : bus.funct3[1] ? a_neg : (a_neg ^ b_neg) && |bus.op_b;
  assign mul_s    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
  assign div_ge   = acc_q[63:31] >= {1'b0, mag_q};
  assign div_diff = acc_q[62:31] - mag_q;
  // acc holds {product hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign acc_step = !f3_q[2] ? {mul_s, acc_q[31:1]} :
                    div_ge ? {div_diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
  assign sel      = !f3_q[2] ? acc_q : {32'd0, f3_q[1] ? acc_q[63:32] : acc_q[31:0]};
  assign fin      = neg_q ? -sel : sel;
  always_comb begin
    state_d = (busy && bus.abort) ? IDLE :
              start_ok ? CALC :
              (state_q == CALC && cnt_q == 6'd1) ? FIN :
              state_q == FIN ? IDLE : state_q;
    cnt_d   = start_ok ? 6'd32 : state_q == CALC ? cnt_q - 6'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      dest_q   <= '0;
      neg_q    <= 1'b0;
      mag_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      waddr_q  <= '0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= fin_ok;
      we_q    <= fin_ok && dest_q != 5'd0;
      if (start_ok) begin
        f3_q   <= bus.funct3;
        dest_q <= bus.dest;
        neg_q  <= neg_new;
        mag_q  <= is_mul ? ma : mb;
        acc_q  <= {32'd0, is_mul ? mb : ma};
      end else if (state_q == CALC)
        acc_q <= acc_step;
      if (fin_ok) begin
        result_q <= (!f3_q[2] && f3_q[1:0] != 2'b00) ? fin[63:32] : fin[31:0];
        waddr_q  <= dest_q;
      end
    end
  end
  assign bus.busy       = busy;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.write_addr = waddr_q;
  assign bus.write_en   = we_q;
endmodule
